lane_tx_scheduler: RTL

- Transmit-side scheduler for the two-lane PHY.
- Accepts two independent byte lanes (data_in0/valid_in0, data_in1/valid_in1), buffers each lane in a small FIFO, and merges them round-robin onto one shared byte channel feeding the serializer.
- Fills every empty slot with comma 0xBC (valid_out=0).
- Emits a comma-only sync preamble after reset so the receiver can align.

---
 rtl/phy_pkg.sv | 10 +
 rtl/lane_tx_scheduler_lane_fifo.sv | 52 +++++
 rtl/lane_tx_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/phy_pkg.sv
// Shared definitions for the two-lane PHY transmit path: comma symbol, scheduler states, lane index.
// No logic; no latency; no backpressure.
// Imported by lane_fifo and lane_tx_scheduler.
package phy_pkg;
  localparam logic [7:0] COMMA = 8'hBC;

  typedef enum logic {SYNC, ACTIVE} sched_state_t;

  typedef logic lane_t;
endpackage

// File: rtl/lane_tx_scheduler_lane_fifo.sv
// Per-lane synchronous byte FIFO with a registered ready flag.
// Latency: a pushed byte is visible at pop_dat (empty=0) after the push edge.
// Backpressure: ready is registered from the count, so a push into a full FIFO is refused even on a pop edge.
module lane_fifo
  import phy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_dat,
  input  logic       pop,
  output logic [7:0] pop_dat,
  output logic       empty,
  output logic       ready
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push   = push && ready;
  assign do_pop    = pop && !empty;
  assign empty     = (count == '0);
  assign pop_dat   = mem[rd_ptr];
  assign count_nxt = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

  // Storage carries no reset; the pointers and count define what is live.
  always_ff @(posedge clk_4f) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      ready <= (count_nxt < (AW+1)'(DEPTH));
    end
  end
endmodule

// File: rtl/lane_tx_scheduler.sv
// Two-lane round-robin merge onto one byte channel with comma idle fill and post-reset sync preamble.
// Latency: 2 edges from push into an empty FIFO to data_out; optional PERIODIC_COMMA_EN forces periodic commas.
// Backpressure: per-lane ready from the FIFOs; refused bytes set sticky overflow; output never stalls.
module lane_tx_scheduler
  import phy_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_COMMAS  = 4,
  parameter int COMMA_PERIOD = 64
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic       valid_in0,
  output logic       ready_in0,
  input  logic [7:0] data_in1,
  input  logic       valid_in1,
  output logic       ready_in1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       lane_out,
  output logic       synced,
  output logic       overflow0,
  output logic       overflow1
);
  localparam int SCW = $clog2(SYNC_COMMAS + 1);

  sched_state_t   state;
  logic [SCW-1:0] sync_cnt;
  lane_t          last_grant;
  lane_t          grant;
  logic           grant_vld;
  logic           force_comma;
  logic           empty0, empty1;
  logic [7:0]     pop_dat0, pop_dat1;
  logic           s1_vld;
  logic [7:0]     s1_dat;
  lane_t          s1_lane;

  lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .push     (valid_in0),
    .push_dat (data_in0),
    .pop      (grant_vld && (grant == 1'b0)),
    .pop_dat  (pop_dat0),
    .empty    (empty0),
    .ready    (ready_in0)
  );

  lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .push     (valid_in1),
    .push_dat (data_in1),
    .pop      (grant_vld && (grant == 1'b1)),
    .pop_dat  (pop_dat1),
    .empty    (empty1),
    .ready    (ready_in1)
  );

`ifdef PERIODIC_COMMA_EN
  localparam int PCW = $clog2(COMMA_PERIOD + 1);
  logic [PCW-1:0] slot_cnt;

  assign force_comma = (state == ACTIVE) && (slot_cnt == PCW'(COMMA_PERIOD - 1));

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset)               slot_cnt <= '0;
    else if (state == SYNC)  slot_cnt <= '0;
    else if (force_comma)    slot_cnt <= '0;
    else                     slot_cnt <= slot_cnt + 1'b1;
  end
`else
  assign force_comma = 1'b0;
`endif

  always_comb begin
    grant_vld = 1'b0;
    grant     = last_grant;
    if (state == ACTIVE && !force_comma) begin
      if (!empty0 && !empty1) begin
        grant_vld = 1'b1;
        grant     = ~last_grant;
      end else if (!empty0) begin
        grant_vld = 1'b1;
        grant     = 1'b0;
      end else if (!empty1) begin
        grant_vld = 1'b1;
        grant     = 1'b1;
      end
    end
  end

  // Grant/pop stage feeds a second register stage that drives the serializer.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      sync_cnt   <= '0;
      synced     <= 1'b0;
      last_grant <= 1'b1;
      s1_vld     <= 1'b0;
      s1_dat     <= COMMA;
      s1_lane    <= 1'b0;
      data_out   <= COMMA;
      valid_out  <= 1'b0;
      lane_out   <= 1'b0;
      overflow0  <= 1'b0;
      overflow1  <= 1'b0;
    end else begin
      if (state == SYNC) begin
        if (sync_cnt == SCW'(SYNC_COMMAS - 1)) begin
          state  <= ACTIVE;
          synced <= 1'b1;
        end else begin
          sync_cnt <= sync_cnt + 1'b1;
        end
      end
      s1_vld <= grant_vld;
      if (grant_vld) begin
        last_grant <= grant;
        s1_dat     <= (grant == 1'b1) ? pop_dat1 : pop_dat0;
        s1_lane    <= grant;
      end
      data_out  <= s1_vld ? s1_dat : COMMA;
      valid_out <= s1_vld;
      if (s1_vld) lane_out <= s1_lane;
      overflow0 <= overflow0 | (valid_in0 & ~ready_in0);
      overflow1 <= overflow1 | (valid_in1 & ~ready_in1);
    end
  end
endmodule
